hw2_multiplier: RTL and testbench

Sequential shift-add unsigned multiplier, the inverse operation to the team's `HW2_divider`. It uses the same `St`/`Done` start-and-complete handshake, so one bench or controller can drive both blocks. A 2·WIDTH-bit product is computed from two WIDTH-bit operands in WIDTH iterations, one add-and-shift per clock. The block is reused as the check engine for divider results: quotient × divisor is compared against the dividend.

---
 rtl/hw2_arith_pkg.sv | 13 +
 rtl/hw2_multiplier.sv | 111 +++++++++++
 tb/tb_hw2_multiplier.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/hw2_arith_pkg.sv
// Shared arithmetic-block definitions: FSM encoding common to the shift-add
// multiplier and the divider, plus the default operand width.
package hw2_arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } hw2_state_e;

   localparam int HW2_WIDTH_DEF = 16;

endpackage

// File: rtl/hw2_multiplier.sv
// Sequential shift-add unsigned multiplier, one add-and-shift per clock.
// St/Done handshake matches the divider so both can share a controller.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for St; operands captured on the accepting edge
// ST_RUN  | WIDTH add-and-shift iterations over the accumulator
// ST_DONE | accumulator holds the product; Product/Done load on exit
module hw2_multiplier
   import hw2_arith_pkg::*;
#(
   parameter int WIDTH = HW2_WIDTH_DEF
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 St,
   input  logic [WIDTH-1:0]     Multiplicand,
   input  logic [WIDTH-1:0]     Multiplier,
   output logic [2*WIDTH-1:0]   Product,
   output logic                 Busy,
   output logic                 Done
);

   localparam int CW = $clog2(WIDTH + 1);

   hw2_state_e           state_q, state_d;
   logic [WIDTH-1:0]     m_q, m_d;
   logic [2*WIDTH:0]     acc_q, acc_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;

   logic [WIDTH:0]       sum;
   logic [2*WIDTH:0]     acc_add;
   logic [2*WIDTH:0]     acc_sh;

   // Datapath: conditional add into the upper half (carry into the spare top
   // bit), then a logical right shift of the full accumulator.
   always_comb begin
      sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, m_q};
      acc_add = acc_q;
      if (acc_q[0]) begin
         acc_add = {sum, acc_q[WIDTH-1:0]};
      end
      acc_sh  = acc_add >> 1;
   end

   // Next-state and register-input logic; Busy also covers the Done cycle,
   // which is spent back in IDLE so a held St restarts immediately after.
   always_comb begin
      state_d   = state_q;
      m_d       = m_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (St) begin
               m_d     = Multiplicand;
               acc_d   = {{(WIDTH+1){1'b0}}, Multiplier};
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            acc_d = acc_sh;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            product_d = acc_q[2*WIDTH-1:0];
            done_d    = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE) || done_d;
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state_q   <= ST_IDLE;
         m_q       <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_q       <= m_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign Product = product_q;
   assign Busy    = busy_q;
   assign Done    = done_q;

endmodule

// File: tb/tb_hw2_multiplier.sv
// Self-checking bench for hw2_multiplier: directed corners, random operands,
// busy-time start, mid-operation reset, held-St throughput and a divider
// result cross-check against a plain-arithmetic reference.
module tb_hw2_multiplier;

   localparam int WIDTH = 16;
   localparam int LAT   = WIDTH + 1;

   logic                Clk;
   logic                Rst_n;
   logic                St;
   logic [WIDTH-1:0]    Multiplicand;
   logic [WIDTH-1:0]    Multiplier;
   logic [2*WIDTH-1:0]  Product;
   logic                Busy;
   logic                Done;

   int n_chk  = 0;
   int n_pass = 0;

   hw2_multiplier #(.WIDTH(WIDTH)) dut (
      .Clk          (Clk),
      .Rst_n        (Rst_n),
      .St           (St),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Product      (Product),
      .Busy         (Busy),
      .Done         (Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   function automatic logic [2*WIDTH-1:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      longint unsigned p;
      p = longint'(a) * longint'(b);
      return p[2*WIDTH-1:0];
   endfunction

   // One operation started at edge k; inj > 0 re-asserts St with other
   // operands at edge k+inj, which must be ignored.
   task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input int inj, output logic [2*WIDTH-1:0] prod);
      int done_at;
      int n_done;
      logic [2*WIDTH-1:0] exp;
      exp = ref_mul(a, b);
      Multiplicand = a;
      Multiplier   = b;
      St = 1'b1;
      tick();
      St = 1'b0;
      Multiplicand = WIDTH'($urandom);
      Multiplier   = WIDTH'($urandom);
      chk({tag, "_busy_start"}, 64'(Busy), 64'd1);
      done_at = -1;
      n_done  = 0;
      prod    = '0;
      for (int i = 1; i <= LAT + 25; i++) begin
         if (i == inj) begin
            St = 1'b1;
            Multiplicand = '1;
            Multiplier   = '1;
         end
         tick();
         if (i == inj) St = 1'b0;
         if (Done) begin
            n_done++;
            if (done_at < 0) begin
               done_at = i;
               prod    = Product;
            end
         end
         if (i == LAT + 1) chk({tag, "_busy_drop"}, 64'(Busy), 64'd0);
      end
      chk({tag, "_latency"}, 64'(done_at), 64'(LAT));
      chk({tag, "_done_count"}, 64'(n_done), 64'd1);
      chk({tag, "_product"}, 64'(prod), 64'(exp));
      chk({tag, "_product_hold"}, 64'(Product), 64'(exp));
   endtask

   initial begin
      logic [2*WIDTH-1:0] p;
      int bad;
      int n_done;
      int d1, d2;
      logic [WIDTH-1:0] dvd [4];
      logic [WIDTH-1:0] dvs [4];
      logic [WIDTH-1:0] q;

      Rst_n = 1'b0;
      St = 1'b0;
      Multiplicand = '0;
      Multiplier = '0;
      tick();
      tick();
      chk("reset_product", 64'(Product), 64'd0);
      chk("reset_done", 64'(Done), 64'd0);
      chk("reset_busy", 64'(Busy), 64'd0);
      Rst_n = 1'b1;
      tick();

      run_op("basic", 16'h8AEA, 16'h0003, 0, p);
      chk("basic_value", 64'(p), 64'h0001_A0BE);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (Product !== 32'h0001_A0BE || Done !== 1'b0) bad++;
      end
      chk("basic_hold50", 64'(bad), 64'd0);

      run_op("max", 16'hFFFF, 16'hFFFF, 0, p);
      chk("max_value", 64'(p), 64'hFFFE_0001);
      run_op("zero", 16'h0000, 16'hABCD, 0, p);

      for (int r = 0; r < 20; r++) begin
         run_op($sformatf("rand%0d", r), WIDTH'($urandom), WIDTH'($urandom), 0, p);
      end

      run_op("busy_st", 16'h1234, 16'h0010, 5, p);
      chk("busy_st_value", 64'(p), 64'h0001_2340);

      // Reset at edge k+8 of an operation.
      Multiplicand = 16'h00FF;
      Multiplier   = 16'h0101;
      St = 1'b1;
      tick();
      St = 1'b0;
      for (int i = 1; i < 8; i++) tick();
      Rst_n = 1'b0;
      tick();
      Rst_n = 1'b1;
      chk("midrst_product", 64'(Product), 64'd0);
      chk("midrst_busy", 64'(Busy), 64'd0);
      n_done = 0;
      for (int i = 0; i < LAT + 8; i++) begin
         tick();
         if (Done) n_done++;
      end
      chk("midrst_no_done", 64'(n_done), 64'd0);
      run_op("restart", 16'h00FF, 16'h0101, 0, p);

      // St held high: second start on the first IDLE edge after Done.
      Multiplicand = 16'h0ABC;
      Multiplier   = 16'h0123;
      St = 1'b1;
      tick();
      d1 = -1;
      d2 = -1;
      for (int i = 1; i <= 3 * LAT; i++) begin
         tick();
         if (Done) begin
            if (d1 < 0) begin
               d1 = i;
               chk("b2b_first", 64'(Product), 64'(ref_mul(16'h0ABC, 16'h0123)));
               Multiplicand = 16'h7777;
               Multiplier   = 16'h0031;
            end else if (d2 < 0) begin
               d2 = i;
               chk("b2b_second", 64'(Product), 64'(ref_mul(16'h7777, 16'h0031)));
            end
         end
         if (d1 >= 0 && i == d1 + 1) St = 1'b0;
      end
      chk("b2b_first_latency", 64'(d1), 64'(LAT));
      chk("b2b_period", 64'(d2 - d1), 64'(WIDTH + 2));
      for (int i = 0; i < LAT + 4; i++) tick();

      // Divider cross-check: quotient x divisor against the dividend.
      dvd[0] = 16'hFFFF; dvs[0] = 16'h0007;
      dvd[1] = 16'h1234; dvs[1] = 16'h0010;
      dvd[2] = 16'h0005; dvs[2] = 16'h0009;
      dvd[3] = 16'hABCD; dvs[3] = 16'h0000;
      for (int v = 0; v < 4; v++) begin
         q = (dvs[v] == '0) ? '1 : WIDTH'(dvd[v] / dvs[v]);
         run_op($sformatf("div%0d", v), q, dvs[v], 0, p);
         if (dvs[v] != '0) begin
            chk($sformatf("div%0d_le", v), 64'(p <= 32'(dvd[v])), 64'd1);
            chk($sformatf("div%0d_rem", v), 64'((32'(dvd[v]) - p) < 32'(dvs[v])), 64'd1);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
